// File: rtl/frame_buffer_writer.sv
// Ping-pong line buffer writer: host pixels in, alternating Buf0/Buf1 writes out.
// Optional `STALL_CNT_EN adds a saturating host stall counter (StallCount).
module frame_buffer_writer #(
   parameter int ADDR_W    = 20,
   parameter int BUF_WORDS = 640
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [23:0]       HostData,
   input  logic              HostValid,
   input  logic              HostLast,
   output logic              HostReady,
   input  logic              Buf0Empty,
   input  logic              Buf1Empty,
   output logic [31:0]       WData,
   output logic              WE0,
   output logic              WE1,
   output logic [ADDR_W-1:0] Addr0,
   output logic [ADDR_W-1:0] Addr1,
`ifdef STALL_CNT_EN
   output logic [15:0]       StallCount,
`endif
   output logic              Buf0Full,
   output logic              Buf1Full
);

   localparam logic [1:0] FILL0 = 2'd0;
   localparam logic [1:0] FILL1 = 2'd1;
   localparam logic [1:0] WAIT0 = 2'd2;
   localparam logic [1:0] WAIT1 = 2'd3;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(BUF_WORDS - 1);

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [ADDR_W-1:0] count;
   logic              in_fill;
   logic              fill_buf;
   logic              accept;
   logic              line_end;
   logic              full0_nxt;
   logic              full1_nxt;

   assign in_fill  = ~state[1];
   assign fill_buf = state[0];
   assign accept   = HostValid & HostReady & in_fill;
   assign line_end = accept & (HostLast | (count == LAST));

   // A drain pulse only counts against a full buffer; a line end always wins.
   always_comb begin
      full0_nxt = Buf0Full & ~Buf0Empty;
      full1_nxt = Buf1Full & ~Buf1Empty;
      if (line_end) begin
         if (fill_buf) full1_nxt = 1'b1;
         else          full0_nxt = 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         FILL0: if (line_end)
                   state_nxt = full1_nxt ? WAIT1 : FILL1;
         FILL1: if (line_end)
                   state_nxt = full0_nxt ? WAIT0 : FILL0;
         WAIT0: if (Buf0Empty & Buf0Full)
                   state_nxt = FILL0;
         WAIT1: if (Buf1Empty & Buf1Full)
                   state_nxt = FILL1;
         default: state_nxt = FILL0;
      endcase
   end

   // Ready needs a fill state both now and next: leaving WAIT costs one cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= FILL0;
         HostReady <= 1'b0;
         WE0       <= 1'b0;
         WE1       <= 1'b0;
         WData     <= '0;
         Addr0     <= '0;
         Addr1     <= '0;
         count     <= '0;
         Buf0Full  <= 1'b0;
         Buf1Full  <= 1'b0;
      end else begin
         state     <= state_nxt;
         HostReady <= in_fill & ~state_nxt[1];
         WE0       <= accept & ~fill_buf;
         WE1       <= accept & fill_buf;
         Buf0Full  <= full0_nxt;
         Buf1Full  <= full1_nxt;
         if (accept) begin
            WData <= {8'h00, HostData};
            if (fill_buf) Addr1 <= count;
            else          Addr0 <= count;
            count <= line_end ? '0 : count + 1'b1;
         end
      end
   end

`ifdef STALL_CNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         StallCount <= '0;
      else if (HostValid & ~HostReady & (StallCount != 16'hFFFF))
         StallCount <= StallCount + 16'd1;
   end
`endif

endmodule
